// File: rtl/l2_pkg.sv
// l2_pkg
//   Line geometry and controller state encoding. Both the L2 cache and its
//   refill controller import this package, so the two always agree on line
//   size and beat count.
//   Contents:
//     LINE_SIZE      - line size in bytes
//     WORDS_PER_LINE - 32-bit words per line, one memory beat each
//     BEAT_BITS      - width of the beat index inside a line
//     l2_state_e     - refill controller state encoding
package l2_pkg;

    localparam int LINE_SIZE      = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int BEAT_BITS      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FETCH  = 2'd2,
        ST_RESP   = 2'd3
    } l2_state_e;

endpackage

// File: rtl/l2_refill_ctrl_if.sv
// l2_refill_ctrl_if
//   Upstream request/response channel of the L2 refill controller.
//   Signals:
//     req_valid  - requester has a read request
//     req_addr   - byte address of the request
//     req_ready  - controller can take a request this cycle
//     resp_valid - one-cycle response strobe
//     resp_data  - requested word
//   Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both high. The requester holds req_valid and req_addr
//   stable until that edge. resp_valid is a single-cycle strobe with no
//   back-pressure, and the controller answers each accepted request exactly
//   once.
//   Modports: master = requester, slave = controller.
interface l2_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/l2_refill_ctrl.sv
// l2_refill_ctrl
//   Serves single-word reads from the L2. A read that misses in the L2
//   refills the whole line from main memory, one word per beat, in beat
//   order 0..3. Each returned beat is written into the L2 on the following
//   cycle. The line is marked valid only with the final beat, so an aborted
//   refill leaves the line invalid.
//   Ports:
//     clk, rst            - clock; asynchronous active-high reset
//     up (slave)          - req_valid/req_addr/req_ready/resp_valid/resp_data
//     l2_addr             - L2 lookup address (the latched request address)
//     l2_hit, l2_r_data   - combinational L2 lookup result for l2_addr
//     fill_en, fill_mark_valid, fill_addr, fill_data - L2 word-fill port
//     mem_rd_en, mem_rd_addr, mem_rd_valid, mem_rd_data - memory read channel
//     miss_count          - saturating L2 miss counter
//     dbg_state_o         - current FSM state
module l2_refill_ctrl
    import l2_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = l2_pkg::LINE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_refill_ctrl_if.slave       up,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    input  logic                  l2_hit,
    input  logic [DATA_WIDTH-1:0] l2_r_data,
    output logic                  fill_en,
    output logic                  fill_mark_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [31:0]           miss_count,
    output l2_state_e             dbg_state_o
);

    localparam int OFF_BITS = $clog2(LINE_SIZE);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WORDS_PER_LINE - 1);

    l2_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEAT_BITS-1:0]  beat_q, beat_d;
    logic                  gap_q, gap_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [31:0]           miss_q, miss_d;
    logic                  fill_en_q, fill_en_d;
    logic                  fill_mark_q, fill_mark_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
    logic [ADDR_WIDTH-1:0] beat_addr;

    // Word address of the current beat within the latched line.
    assign beat_addr = {addr_q[ADDR_WIDTH-1:OFF_BITS], beat_q, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            gap_q       <= 1'b0;
            resp_data_q <= '0;
            miss_q      <= '0;
            fill_en_q   <= 1'b0;
            fill_mark_q <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            resp_data_q <= resp_data_d;
            miss_q      <= miss_d;
            fill_en_q   <= fill_en_d;
            fill_mark_q <= fill_mark_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        gap_d         = gap_q;
        resp_data_d   = resp_data_q;
        miss_d        = miss_q;
        fill_en_d     = 1'b0;
        fill_mark_d   = 1'b0;
        fill_addr_d   = fill_addr_q;
        fill_data_d   = fill_data_q;
        up.req_ready  = 1'b0;
        up.resp_valid = 1'b0;
        mem_rd_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                up.req_ready = 1'b1;
                if (up.req_valid) begin
                    addr_d  = up.req_addr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (l2_hit) begin
                    resp_data_d = l2_r_data;
                    state_d     = ST_RESP;
                end else begin
                    beat_d  = '0;
                    gap_d   = 1'b0;
                    if (miss_q != 32'hFFFF_FFFF) begin
                        miss_d = miss_q + 32'd1;
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // gap_q is the one idle cycle between beats. A read is
                // outstanding only while mem_rd_en is high, so mem_rd_valid
                // during the gap is ignored.
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    mem_rd_en = 1'b1;
                    if (mem_rd_valid) begin
                        fill_en_d   = 1'b1;
                        fill_addr_d = beat_addr;
                        fill_data_d = mem_rd_data;
                        fill_mark_d = (beat_q == LAST_BEAT);
                        if (beat_q == addr_q[OFF_BITS-1:2]) begin
                            resp_data_d = mem_rd_data;
                        end
                        if (beat_q == LAST_BEAT) begin
                            state_d = ST_RESP;
                        end else begin
                            beat_d = beat_q + 1'b1;
                            gap_d  = 1'b1;
                        end
                    end
                end
            end
            ST_RESP: begin
                up.resp_valid = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign up.resp_data      = resp_data_q;
    assign l2_addr           = addr_q;
    assign mem_rd_addr       = beat_addr;
    assign fill_en           = fill_en_q;
    assign fill_mark_valid   = fill_mark_q;
    assign fill_addr         = fill_addr_q;
    assign fill_data         = fill_data_q;
    assign miss_count        = miss_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_l2_refill_ctrl.sv
// tb_l2_refill_ctrl
//   Directed bench for l2_refill_ctrl. It contains a small L2 array model
//   and a variable-latency memory model. A negedge monitor keeps logs and
//   protocol counters, and a scoreboard of expected responses is held in
//   exp_q.
module tb_l2_refill_ctrl;
    import l2_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- DUT ----------------
    l2_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) up_if ();

    logic [31:0] l2_addr, l2_r_data, fill_addr, fill_data, mem_rd_addr, mem_rd_data, miss_count;
    logic        l2_hit, fill_en, fill_mark_valid, mem_rd_en, mem_rd_valid;
    l2_state_e   dbg_state;

    l2_refill_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .up              (up_if),
        .l2_addr         (l2_addr),
        .l2_hit          (l2_hit),
        .l2_r_data       (l2_r_data),
        .fill_en         (fill_en),
        .fill_mark_valid (fill_mark_valid),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_valid    (mem_rd_valid),
        .mem_rd_data     (mem_rd_data),
        .miss_count      (miss_count),
        .dbg_state_o     (dbg_state)
    );

    // ---------------- L2 model (addresses below 0x800) ----------------
    logic [31:0] l2_mem [0:511];
    logic        l2_vld [0:127];
    assign l2_hit    = l2_vld[l2_addr[10:4]];
    assign l2_r_data = l2_mem[l2_addr[10:2]];

    // ---------------- memory model ----------------
    logic [31:0] mem_lat     = 32'd3;
    logic [31:0] wait_cnt    = 32'd0;
    logic        inject_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h20) return 32'hA0 + {30'd0, a[3:2]};
        return 32'hD000_0000 | a;
    endfunction

    assign mem_rd_valid = (mem_rd_en && (wait_cnt >= mem_lat)) || inject_valid;
    assign mem_rd_data  = mem_word(mem_rd_addr);

    initial forever begin
        @(posedge clk);
        if (mem_rd_en && !mem_rd_valid) wait_cnt <= wait_cnt + 32'd1;
        else                            wait_cnt <= 32'd0;
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_q[$];
    int          n_pushed = 0;
    logic [31:0] rd_log[$];
    logic [31:0] fill_addr_log[$];
    logic [31:0] fill_data_log[$];
    logic        mark_log[$];
    int          done_cyc[$];
    int          en_cycles = 0, resp_cnt = 0, last_resp_cyc = 0;
    int          ready_viol = 0, stab_viol = 0, gap_viol = 0, fill_viol = 0, mark_viol = 0;
    logic        prev_en = 1'b0, prev_valid = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_en    = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (up_if.req_ready && dbg_state != ST_IDLE) ready_viol++;
            if (mem_rd_en) en_cycles++;
            if (mem_rd_en && prev_en && !prev_valid && mem_rd_addr != prev_addr) stab_viol++;
            if (mem_rd_en && prev_en && prev_valid) gap_viol++;
            if (fill_en != (prev_en && prev_valid)) fill_viol++;
            if (fill_mark_valid && !(fill_en && fill_addr[3:2] == 2'd3 && dbg_state == ST_RESP)) mark_viol++;
            if (fill_en) begin
                fill_addr_log.push_back(fill_addr);
                fill_data_log.push_back(fill_data);
                mark_log.push_back(fill_mark_valid);
                l2_mem[fill_addr[10:2]] = fill_data;
                if (fill_mark_valid) l2_vld[fill_addr[10:4]] = 1'b1;
            end
            if (mem_rd_en && mem_rd_valid) begin
                rd_log.push_back(mem_rd_addr);
                done_cyc.push_back(cyc);
            end
            if (up_if.resp_valid) begin
                resp_cnt++;
                last_resp_cyc = cyc;
                if (exp_q.size() != 0) check_eq("resp_data", up_if.resp_data, exp_q.pop_front());
                else                   check_eq("resp_extra", resp_cnt, n_pushed);
            end
            prev_en    = mem_rd_en;
            prev_valid = mem_rd_valid;
            prev_addr  = mem_rd_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        fill_addr_log.delete();
        fill_data_log.delete();
        mark_log.delete();
        done_cyc.delete();
        en_cycles = 0;
    endtask

    task automatic push_exp(input logic [31:0] d);
        exp_q.push_back(d);
        n_pushed++;
    endtask

    // Holds req_valid until the handshake; acc is the handshake cycle and
    // rc the response count seen at that moment.
    task automatic send_req(input logic [31:0] a, output int acc, output int rc);
        acc = -1;
        rc  = 0;
        up_if.req_valid = 1'b1;
        up_if.req_addr  = a;
        for (int i = 0; i < 400; i++) begin
            if (up_if.req_ready) begin
                acc = cyc;
                rc  = resp_cnt;
                tick();
                break;
            end
            tick();
        end
        up_if.req_valid = 1'b0;
        check_eq("req_accepted", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 400; i++) begin
            if (resp_cnt >= target) break;
            tick();
        end
        tick();
        check_eq("resp_count", resp_cnt, target);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_state"},      32'(dbg_state), 32'(ST_IDLE));
        check_eq({pfx, "_req_ready"},  32'(up_if.req_ready), 32'd1);
        check_eq({pfx, "_resp_valid"}, 32'(up_if.resp_valid), 32'd0);
        check_eq({pfx, "_fill_en"},    32'(fill_en), 32'd0);
        check_eq({pfx, "_fill_mark"},  32'(fill_mark_valid), 32'd0);
        check_eq({pfx, "_mem_rd_en"},  32'(mem_rd_en), 32'd0);
        check_eq({pfx, "_l2_addr"},    l2_addr, 32'd0);
        check_eq({pfx, "_resp_data"},  up_if.resp_data, 32'd0);
        check_eq({pfx, "_fill_addr"},  fill_addr, 32'd0);
        check_eq({pfx, "_fill_data"},  fill_data, 32'd0);
        check_eq({pfx, "_miss_count"}, miss_count, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc, rc, fcnt, ecnt;
        logic [31:0] line_addr [4];
        line_addr[0] = 32'h200; line_addr[1] = 32'h204;
        line_addr[2] = 32'h208; line_addr[3] = 32'h20C;
        for (int i = 0; i < 512; i++) l2_mem[i] = 32'd0;
        for (int i = 0; i < 128; i++) l2_vld[i] = 1'b0;
        l2_mem[32'h100 >> 2] = 32'hCAFE_0001;
        l2_vld[32'h100 >> 4] = 1'b1;
        up_if.req_valid = 1'b0;
        up_if.req_addr  = 32'd0;

        // Reset values while rst is held.
        repeat (2) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Preloaded hit at 0x100.
        clear_logs();
        push_exp(32'hCAFE_0001);
        send_req(32'h100, acc, rc);
        wait_resp(1);
        check_eq("hit_latency", 32'(last_resp_cyc - acc), 32'd2);
        check_eq("hit_no_mem", 32'(en_cycles), 32'd0);
        check_eq("hit_miss_count", miss_count, 32'd0);

        // Miss at 0x208, 3-cycle memory latency.
        clear_logs();
        push_exp(32'h0000_00A2);
        send_req(32'h208, acc, rc);
        wait_resp(2);
        tick();
        check_eq("miss_beats", 32'(rd_log.size()), 32'd4);
        check_eq("miss_fills", 32'(fill_addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("miss_rd_addr%0d", i), rd_log[i], line_addr[i]);
            check_eq($sformatf("miss_fill_addr%0d", i), fill_addr_log[i], line_addr[i]);
            check_eq($sformatf("miss_fill_data%0d", i), fill_data_log[i], 32'hA0 + 32'(i));
            check_eq($sformatf("miss_mark%0d", i), 32'(mark_log[i]), 32'(i == 3));
        end
        for (int i = 1; i < 4; i++)
            check_eq($sformatf("miss_beat_spacing%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'd5);
        check_eq("miss_resp_hold", up_if.resp_data, 32'h0000_00A2);
        check_eq("miss_count_1", miss_count, 32'd1);

        // Same address again is now an L2 hit.
        clear_logs();
        push_exp(32'h0000_00A2);
        send_req(32'h208, acc, rc);
        wait_resp(3);
        check_eq("rehit_no_mem", 32'(en_cycles), 32'd0);
        check_eq("rehit_no_fill", 32'(fill_addr_log.size()), 32'd0);
        check_eq("rehit_latency", 32'(last_resp_cyc - acc), 32'd2);
        check_eq("rehit_miss_count", miss_count, 32'd1);

        // Second request held high during a refill.
        clear_logs();
        push_exp(32'hD000_0600);
        push_exp(32'hD000_0300);
        send_req(32'h600, acc, rc);
        send_req(32'h300, acc, rc);
        check_eq("held_accept_after_resp", 32'(rc), 32'd4);
        wait_resp(5);
        check_eq("held_beats", 32'(rd_log.size()), 32'd8);
        check_eq("held_miss_count", miss_count, 32'd3);

        // Reset in the middle of a refill to 0x400.
        clear_logs();
        send_req(32'h400, acc, rc);
        for (int i = 0; i < 400; i++) begin
            if (rd_log.size() >= 2) break;
            tick();
        end
        check_eq("abort_two_beats", 32'(rd_log.size()), 32'd2);
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        tick();
        rst = 1'b0;
        fcnt = fill_addr_log.size();
        ecnt = en_cycles;
        inject_valid = 1'b1;
        repeat (3) tick();
        inject_valid = 1'b0;
        tick();
        check_eq("late_valid_no_fill", 32'(fill_addr_log.size()), 32'(fcnt));
        check_eq("late_valid_no_rd", 32'(en_cycles), 32'(ecnt));
        check_eq("abort_line_invalid", 32'(l2_vld[32'h400 >> 4]), 32'd0);
        clear_logs();
        push_exp(32'hD000_0400);
        send_req(32'h400, acc, rc);
        wait_resp(6);
        check_eq("refetch_beats", 32'(rd_log.size()), 32'd4);
        check_eq("refetch_miss_count", miss_count, 32'd1);

        // Zero-latency memory.
        mem_lat = 32'd0;
        clear_logs();
        push_exp(32'hD000_0704);
        send_req(32'h704, acc, rc);
        wait_resp(7);
        check_eq("zl_fills", 32'(fill_addr_log.size()), 32'd4);
        check_eq("zl_en_cycles", 32'(en_cycles), 32'd4);
        for (int i = 1; i < 4; i++)
            check_eq($sformatf("zl_beat_spacing%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'd2);
        check_eq("zl_resp_hold", up_if.resp_data, 32'hD000_0704);
        check_eq("zl_miss_count", miss_count, 32'd2);

        // Protocol counters and scoreboard drain.
        repeat (3) tick();
        check_eq("ready_only_idle", 32'(ready_viol), 32'd0);
        check_eq("rd_addr_stable", 32'(stab_viol), 32'd0);
        check_eq("rd_en_gap", 32'(gap_viol), 32'd0);
        check_eq("fill_after_beat", 32'(fill_viol), 32'd0);
        check_eq("mark_last_beat", 32'(mark_viol), 32'd0);
        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
